// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - round-robin arbiter giving two requesters serialized access to a 2R1W register file
// Optional build macro RF_R0_PROTECT_EN: writes to address 0 complete normally but never strobe RF_WRITE.
module rf_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADDR_WIDTH-1:0] A_ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] A_ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] A_ADDR_W,
  input  logic [DATA_WIDTH-1:0] A_DATA_W,
  output logic                  A_GNT,
  output logic                  A_DONE,
  output logic [DATA_WIDTH-1:0] A_RDATA1,
  output logic [DATA_WIDTH-1:0] A_RDATA2,
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADDR_WIDTH-1:0] B_ADDR_R1,
  input  logic [ADDR_WIDTH-1:0] B_ADDR_R2,
  input  logic [ADDR_WIDTH-1:0] B_ADDR_W,
  input  logic [DATA_WIDTH-1:0] B_DATA_W,
  output logic                  B_GNT,
  output logic                  B_DONE,
  output logic [DATA_WIDTH-1:0] B_RDATA1,
  output logic [DATA_WIDTH-1:0] B_RDATA2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R1,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_R2,
  output logic [ADDR_WIDTH-1:0] RF_ADDR_W,
  output logic [DATA_WIDTH-1:0] RF_DATA_W,
  output logic                  RF_READ,
  output logic                  RF_WRITE,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R1,
  input  logic [DATA_WIDTH-1:0] RF_DATA_R2
);

  typedef enum logic [2:0] {IDLE, WR, RD, RD_CAP, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic                  ptr;      // 0 = A has priority on contention, 1 = B
  logic                  owner;    // requester of the transaction in flight
  logic                  grant_a;
  logic                  grant_b;
  logic                  wr_ok;
  logic [ADDR_WIDTH-1:0] lat_r1;
  logic [ADDR_WIDTH-1:0] lat_r2;
  logic [ADDR_WIDTH-1:0] lat_w;
  logic [DATA_WIDTH-1:0] lat_d;

`ifdef RF_R0_PROTECT_EN
  assign wr_ok = (lat_w != '0);
`else
  assign wr_ok = 1'b1;
`endif

  // Requests only matter in IDLE; the pointer breaks ties
  assign grant_b = (state == IDLE) && B_REQ && (!A_REQ || ptr);
  assign grant_a = (state == IDLE) && A_REQ && !grant_b;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr    <= 1'b0;
      owner  <= 1'b0;
      lat_r1 <= '0;
      lat_r2 <= '0;
      lat_w  <= '0;
      lat_d  <= '0;
    end else if (grant_a || grant_b) begin
      owner  <= grant_b;
      ptr    <= grant_a;
      lat_r1 <= grant_b ? B_ADDR_R1 : A_ADDR_R1;
      lat_r2 <= grant_b ? B_ADDR_R2 : A_ADDR_R2;
      lat_w  <= grant_b ? B_ADDR_W  : A_ADDR_W;
      lat_d  <= grant_b ? B_DATA_W  : A_DATA_W;
    end
  end

  // Read data is captured only at the end of RD_CAP; a reset there discards it
  always_ff @(posedge CLK) begin
    if (RST) begin
      A_RDATA1 <= '0;
      A_RDATA2 <= '0;
      B_RDATA1 <= '0;
      B_RDATA2 <= '0;
    end else if (state == RD_CAP) begin
      if (owner) begin
        B_RDATA1 <= RF_DATA_R1;
        B_RDATA2 <= RF_DATA_R2;
      end else begin
        A_RDATA1 <= RF_DATA_R1;
        A_RDATA2 <= RF_DATA_R2;
      end
    end
  end

  always_comb begin
    next_state = state;
    A_GNT      = 1'b0;
    B_GNT      = 1'b0;
    A_DONE     = 1'b0;
    B_DONE     = 1'b0;
    RF_READ    = 1'b0;
    RF_WRITE   = 1'b0;
    RF_ADDR_R1 = '0;
    RF_ADDR_R2 = '0;
    RF_ADDR_W  = '0;
    RF_DATA_W  = '0;
    case (state)
      IDLE: begin
        if (grant_a) begin
          next_state = A_WE ? WR : RD;
        end else if (grant_b) begin
          next_state = B_WE ? WR : RD;
        end
      end
      WR: begin
        A_GNT      = !owner;
        B_GNT      = owner;
        RF_WRITE   = wr_ok;
        RF_ADDR_W  = lat_w;
        RF_DATA_W  = lat_d;
        next_state = DONE;
      end
      RD: begin
        A_GNT      = !owner;
        B_GNT      = owner;
        RF_READ    = 1'b1;
        RF_ADDR_R1 = lat_r1;
        RF_ADDR_R2 = lat_r2;
        next_state = RD_CAP;
      end
      RD_CAP: begin
        RF_READ    = 1'b1;
        RF_ADDR_R1 = lat_r1;
        RF_ADDR_R2 = lat_r2;
        next_state = DONE;
      end
      DONE: begin
        A_DONE     = !owner;
        B_DONE     = owner;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule
